// File: rtl/rx_psdu_deframer.sv
// rx_psdu_deframer: strips the SERVICE field from a descrambled bit stream and packs PSDU bits LSB-first into bytes
module rx_psdu_deframer #(
  parameter int LEN_W = 12,
  parameter int SERVICE_BITS = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LEN_W-1:0] Length,
  input  logic             En,
  input  logic             Data,
  output logic [7:0]       Byte_out,
  output logic             Byte_valid,
  output logic             Byte_last,
  output logic             Busy,
  output logic             Done,
  output logic             Err_service
);
  typedef enum logic [1:0] {IDLE, SERVICE, PSDU, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d, byte_out_q, byte_out_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, err_q, err_d;
  logic in_svc, in_psdu, svc_end, byte_end;
  logic [2:0] pos;
  always_comb begin
    in_svc       = state_q == SERVICE && En && !Start;
    in_psdu      = state_q == PSDU && En && !Start;
    pos          = bit_cnt_q[2:0];
    svc_end      = in_svc && bit_cnt_q == 5'(SERVICE_BITS - 1);
    byte_end     = in_psdu && pos == 3'd7;
    byte_cnt_inc = byte_cnt_q + LEN_W'(1);
    last_d       = byte_end && byte_cnt_inc == len_q;
    valid_d      = byte_end;
    done_d       = last_d || (svc_end && len_q == '0);
    state_d      = Start ? SERVICE :
                   svc_end ? (len_q == '0 ? DRAIN : PSDU) :
                   last_d ? DRAIN : state_q;
    len_d        = Start ? Length : len_q;
    bit_cnt_d    = Start ? {4'd0, En} : (in_svc || in_psdu) ? bit_cnt_q + 5'd1 : bit_cnt_q;
    byte_cnt_d   = Start ? '0 : byte_end ? byte_cnt_inc : byte_cnt_q;
    shreg_d      = in_psdu ? ((shreg_q & ~(8'd1 << pos)) | (8'(Data) << pos)) : shreg_q;
    byte_out_d   = byte_end ? {Data, shreg_q[6:0]} : byte_out_q;
    err_d        = Start ? (En && Data) : (err_q || (in_svc && Data));
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      byte_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      byte_out_q <= byte_out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  assign Byte_out    = byte_out_q;
  assign Byte_valid  = valid_q;
  assign Byte_last   = last_q;
  assign Done        = done_q;
  assign Err_service = err_q;
  assign Busy        = state_q == SERVICE || state_q == PSDU;
endmodule
